// File: rtl/icache_read_arbiter.sv
// Shares the I-cache read port between fetch and the next-line prefetcher, tracks the single
// outstanding read, routes its completion to the owner and drains reads cancelled by a flush.
module icache_read_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_done_o,
    input  logic              pf_req_i,
    input  logic [ADDR_W-1:0] pf_addr_i,
    output logic              pf_gnt_o,
    output logic              pf_done_o,
    output logic              cache_req_o,
    output logic [ADDR_W-1:0] cache_addr_o,
    input  logic              cache_ready_i,
    input  logic              cache_done_i,
    output logic              busy_o,
    output logic [1:0]        dbg_state_o,
    output logic [3:0]        dbg_starve_o
);

    // Handshake: a requester holds req (and its address) until the cycle its gnt is high;
    // gnt is a one-cycle pulse. cache_req_o stays high until the cycle cache_ready_i is seen.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              owner_pf_q, owner_pf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cache_req_q;
    logic              pick_pf;

    always_comb begin
        state_d      = state_q;
        owner_pf_d   = owner_pf_q;
        addr_d       = addr_q;
        fetch_gnt_o  = 1'b0;
        pf_gnt_o     = 1'b0;
        fetch_done_o = 1'b0;
        pf_done_o    = 1'b0;
        pick_pf      = pf_req_i && (!fetch_req_i || (starve_q == STARVE_LIM));

        case (state_q)
            S_IDLE: begin
                if (!flush_i && (fetch_req_i || pf_req_i)) begin
                    fetch_gnt_o = !pick_pf;
                    pf_gnt_o    = pick_pf;
                    owner_pf_d  = pick_pf;
                    addr_d      = pick_pf ? pf_addr_i : fetch_addr_i;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (cache_ready_i) begin
                    state_d = flush_i ? S_DRAIN : S_WAIT;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cache_done_i) begin
                    state_d = S_IDLE;
                    if (!flush_i) begin
                        fetch_done_o = !owner_pf_q;
                        pf_done_o    = owner_pf_q;
                    end
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cache_done_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pulses stay quiet during the reset cycle whatever state is still registered.
        if (!rst_n_i) begin
            fetch_gnt_o  = 1'b0;
            pf_gnt_o     = 1'b0;
            fetch_done_o = 1'b0;
            pf_done_o    = 1'b0;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!pf_req_i || pf_gnt_o) begin
            starve_d = 4'd0;
        end else if (fetch_gnt_o && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            starve_q    <= 4'd0;
            owner_pf_q  <= 1'b0;
            addr_q      <= '0;
            cache_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            owner_pf_q  <= owner_pf_d;
            addr_q      <= addr_d;
            cache_req_q <= (state_d == S_REQ);
        end
    end

    assign cache_req_o  = cache_req_q;
    assign cache_addr_o = addr_q;
    assign busy_o       = (state_q != S_IDLE);
    assign dbg_state_o  = state_q;
    assign dbg_starve_o = starve_q;

    done_only_when_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        cache_done_i |-> (state_q == S_WAIT || state_q == S_DRAIN)
    ) else $error("cache_done_i with no outstanding read");

endmodule

// File: doc/icache_read_arbiter.md
# icache_read_arbiter

Single-port arbiter for the instruction-cache read port. It shares the port between the fetch unit's line requests and the next-line prefetcher's requests, and fetch wins by default. A starvation counter bounds how long the prefetcher can be held off. The block tracks the one outstanding cache read, routes the completion pulse back to the requester that owns it, and discards completions for reads that a flush has cancelled. It sits between the fetch controller / prefetcher and the I-cache read interface.

## Interface
- ADDR_W, 32, width of line address.
- STARVE_MAX, 4, consecutive fetch grants allowed while prefetch waits (1..15).

- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- flush_i  in  1  pipeline flush; cancels pending/outstanding read.
- fetch_req_i  in  1  fetch wants a line; held until fetch_gnt_o.
- fetch_addr_i  in  ADDR_W  fetch line address, stable while fetch_req_i.
- fetch_gnt_o  out  1  one-cycle grant to fetch.
- fetch_done_o  out  1  one-cycle completion for fetch-owned read.
- pf_req_i  in  1  prefetcher wants a line; held until pf_gnt_o.
- pf_addr_i  in  ADDR_W  prefetch line address.
- pf_gnt_o  out  1  one-cycle grant to prefetcher.
- pf_done_o  out  1  one-cycle completion for prefetch-owned read.
- cache_req_o  out  1  read request to cache (registered).
- cache_addr_o  out  ADDR_W  latched address of current read (registered).
- cache_ready_i  in  1  cache accepts request this cycle.
- cache_done_i  in  1  cache read data valid (read_done).
- busy_o  out  1  state != IDLE.

## Operation
- States: IDLE, REQ (cache_req_o high, waiting cache_ready_i), WAIT (accepted, waiting cache_done_i), DRAIN (cancelled read outstanding).
- IDLE: no flush_i and at least one request -> select owner, assert that gnt combinationally, latch address and owner, go to REQ. flush_i in IDLE -> no grant, stay in IDLE.
- Selection: fetch only -> fetch. pf only -> pf. Both -> fetch, unless starve_cnt == STARVE_MAX, then pf.
- starve_cnt (4 bit): +1 on each fetch grant while pf_req_i is high. Cleared on a pf grant, or on any cycle with pf_req_i low. Saturates at STARVE_MAX.
- REQ:
  - cache_ready_i -> WAIT.
  - flush_i without ready -> IDLE; the request is dropped and no done is sent.
  - flush_i with ready -> DRAIN.
- WAIT:
  - cache_done_i and no flush -> pulse the owner's done_o the same cycle, go to IDLE.
  - flush_i with cache_done_i -> IDLE, done suppressed.
  - flush_i alone -> DRAIN.
- DRAIN: cache_done_i -> IDLE, no done pulse. flush_i is ignored.
- cache_done_i outside WAIT/DRAIN is ignored; this is a cache protocol error, flagged by an assertion.
- cache_addr_o changes only on a grant. A flush never alters the latched owner until the next grant.

## Timing
- Reset (rst_n_i low at an edge):
  - state = IDLE, starve_cnt = 0, owner = fetch, cache_addr_o = 0, cache_req_o = 0.
  - All gnt, done and busy outputs are 0.
- Grant is combinational in the IDLE cycle (cycle N). cache_req_o is high from cycle N+1.
- Minimum read: grant at N, ready at N+1, done at N+2 (done_o at N+2), next grant at N+3.
- The cache never asserts cache_done_i in the same cycle as acceptance.
- Only one read is outstanding at a time; there is no grant while busy_o is high.
- rst_n_i low mid-read returns to IDLE with no done pulse. The cache is required to be reset together with the arbiter.

## Test plan
- **Single fetch:** fetch_req with addr 0x40 at cycle 1, ready at 2, done at 4.
  - Required: fetch_gnt at 1; cache_req 2..2 with addr 0x40; fetch_done at 4; busy 2..4; idle at 5.
- **Contention, STARVE_MAX=4:** fetch_req and pf_req both held continuously, ready and done immediate.
  - Required: grants in the order F,F,F,F,P,F,F,F,F,P. starve_cnt reaches 4 before each P.
- **Flush in REQ:** flush at the cycle after grant, ready=0.
  - Required: IDLE next cycle, cache_req drops, no done. A later cache_done_i is ignored and the assertion fires.
- **Flush in WAIT:** pf read accepted, flush 1 cycle later, cache_done_i 3 cycles later.
  - Required: DRAIN, pf_done stays 0, IDLE after done, and a fetch grant is possible the following cycle.
- **Simultaneous events:**
  - flush together with cache_ready_i in REQ -> DRAIN.
  - flush together with cache_done_i in WAIT -> IDLE, done suppressed.
  - flush in IDLE with fetch_req high -> no grant that cycle, grant the next cycle.
- **Reset mid-WAIT:** rst_n_i low for 1 cycle.
  - Required: all outputs 0, starve_cnt 0, and a fetch request is granted on the first cycle after reset.
